// File: rtl/seq_detect_ctrl_if.sv
// Serial bit-stream handshake between a bit source (master) and the
// pattern detector (slave).
interface seq_detect_ctrl_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: run-time pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping matching, match counting and threshold halt.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_threshold,
  input  logic               start,
  input  logic               stop,
  seq_detect_ctrl_if.slave   stream,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               irq,
  output logic               busy,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [MAX_LEN-1:0] pattern_q, pattern_next;
  logic [LEN_W-1:0]   len_q, len_next;
  logic               overlap_q, overlap_next;
  logic [CNT_W-1:0]   threshold_q, threshold_next;
  logic [MAX_LEN-1:0] history, history_next;
  logic [LEN_W-1:0]   fill, fill_next, fill_inc;
  logic [CNT_W-1:0]   count_next, count_inc;
  logic               irq_next, err_next, match_next;
  logic [MAX_LEN:0]   window, len_mask;
  logic               accept, hit, len_legal;

  // The window carries one extra (never compared) bit so every history bit feeds it.
  assign window    = {history, stream.in_bit};
  assign len_mask  = {1'b0, ~({MAX_LEN{1'b1}} << len_q)};
  assign accept    = (state == RUN) && stream.in_valid && !stop;
  assign hit       = accept && ((fill + LEN_W'(1)) >= len_q) &&
                     (((window ^ {1'b0, pattern_q}) & len_mask) == '0);
  assign fill_inc  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  assign count_inc = (match_count == '1) ? match_count : match_count + CNT_W'(1);
  assign len_legal = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));

  assign stream.in_ready = (state == RUN);
  assign busy            = (state == RUN);

  always_comb begin
    state_next     = state;
    pattern_next   = pattern_q;
    len_next       = len_q;
    overlap_next   = overlap_q;
    threshold_next = threshold_q;
    history_next   = history;
    fill_next      = fill;
    count_next     = match_count;
    irq_next       = irq;
    err_next       = cfg_err;
    match_next     = 1'b0;

    case (state)
      IDLE: begin
        if (cfg_we) begin
          pattern_next   = cfg_pattern;
          len_next       = cfg_len;
          overlap_next   = cfg_overlap;
          threshold_next = cfg_threshold;
        end
        if (start && !stop) begin
          if (len_legal) begin
            history_next = '0;
            fill_next    = '0;
            count_next   = '0;
            irq_next     = 1'b0;
            err_next     = 1'b0;
            state_next   = RUN;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop) begin
          history_next = '0;
          fill_next    = '0;
          state_next   = IDLE;
        end else if (accept) begin
          history_next = window[MAX_LEN-1:0];
          fill_next    = fill_inc;
          if (hit) begin
            match_next = 1'b1;
            count_next = count_inc;
            // Non-overlap: the next match must be built from fresh bits only.
            if (!overlap_q) fill_next = '0;
            if ((threshold_q != '0) && (count_inc == threshold_q)) begin
              irq_next   = 1'b1;
              state_next = HALT;
            end
          end
        end
      end

      HALT: begin
        if (stop) begin
          history_next = '0;
          fill_next    = '0;
          state_next   = IDLE;
        end else if (start) begin
          history_next = '0;
          fill_next    = '0;
          count_next   = '0;
          irq_next     = 1'b0;
          state_next   = RUN;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q   <= '0;
      len_q       <= LEN_W'(1);
      overlap_q   <= 1'b1;
      threshold_q <= '0;
      history     <= '0;
      fill        <= '0;
      match_count <= '0;
      irq         <= 1'b0;
      cfg_err     <= 1'b0;
      match       <= 1'b0;
    end else begin
      pattern_q   <= pattern_next;
      len_q       <= len_next;
      overlap_q   <= overlap_next;
      threshold_q <= threshold_next;
      history     <= history_next;
      fill        <= fill_next;
      match_count <= count_next;
      irq         <= irq_next;
      cfg_err     <= err_next;
      match       <= match_next;
    end
  end

endmodule
